pong_score: RTL and testbench

- Scorekeeper and match sequencer for the Pong datapath. Consumes the ball block's `point_1`/`point_2` outputs and owns per-player scores.
- Runs the match FSM: idle, play, post-point pause, game over.
- Drives `ball_hold` back to the ball block so the ball is parked at centre whenever play is suspended.
- Feeds the score/status display logic.

---
 rtl/pong_pkg.sv | 37 +++
 rtl/pong_score_if.sv | 35 +++
 rtl/pong_score_rise_detect.sv | 30 +++
 rtl/pong_score.sv | 152 +++++++++++++++
 tb/tb_pong_score.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg
// Shared definitions for the Pong datapath: match state encoding, winner
// codes, score width and the arena geometry used by the ball and paddle
// blocks, so scoring, motion and display all work from the same numbers.
// No ports; import with "import pong_pkg::*;".
package pong_pkg;

  // Match sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  // Winner codes as presented on the winner output.
  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10
  } winner_t;

  // Score width; the match ends at WIN_SCORE <= 15, so 4 bits never wrap.
  localparam int SCORE_W = 4;

  // Arena geometry in pixels, shared with the ball/bar blocks.
  localparam int ARENA_W    = 640;
  localparam int ARENA_H    = 480;
  localparam int BALL_SIZE  = 8;
  localparam int BAR_W      = 8;
  localparam int BAR_H      = 64;
  localparam int BAR_1_X    = 16;
  localparam int BAR_2_X    = ARENA_W - 16 - BAR_W;
  localparam int BALL_HOME_X = (ARENA_W - BALL_SIZE) / 2;
  localparam int BALL_HOME_Y = (ARENA_H - BALL_SIZE) / 2;

endpackage

// File: rtl/pong_score_if.sv
// pong_score_if
// Bundles the scorekeeper's control inputs and score/status outputs.
//   start      : debounced start pulse (master -> slave)
//   point_1/2  : point levels from the ball block (master -> slave)
//   score_1/2  : per-player scores (slave -> master)
//   ball_hold  : park ball at centre while play is suspended
//   playing    : high only while the rally is live
//   game_over  : high only once the match is decided
//   winner     : 00 none, 01 player 1, 10 player 2
// The slave modport is used by pong_score; the master side is whoever
// drives the inputs and consumes the status (ball/display logic, or a bench).
interface pong_score_if;
  import pong_pkg::*;

  logic               start;
  logic               point_1;
  logic               point_2;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic               ball_hold;
  logic               playing;
  logic               game_over;
  logic [1:0]         winner;

  modport master (
    output start, point_1, point_2,
    input  score_1, score_2, ball_hold, playing, game_over, winner
  );

  modport slave (
    input  start, point_1, point_2,
    output score_1, score_2, ball_hold, playing, game_over, winner
  );

endinterface

// File: rtl/pong_score_rise_detect.sv
// rise_detect
// One-bit rising-edge detector. The previous sample is registered; rise is
// high in the cycle where din is 1 and the previous sample was 0, so a level
// held for many cycles produces a single pulse.
//   clk   : system clock
//   reset : synchronous active-high, clears the history to 0
//   din   : level input
//   rise  : single-cycle pulse on a 0 -> 1 transition of din
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  // History register updates every cycle regardless of the consumer's state,
  // so an edge that was ignored is never seen again later.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/pong_score.sv
// pong_score
// Scorekeeper and match sequencer. Counts rising edges of point_1/point_2
// while the rally is live, pauses play for HOLD_CYCLES after each point and
// declares a winner when a score reaches WIN_SCORE.
//   clk   : system clock, rising edge
//   reset : synchronous active-high, returns to IDLE with zero scores
//   bus   : pong_score_if.slave (start, point_1/2 in; scores, status out)
// Parameters:
//   WIN_SCORE   : score that ends the match, 1..15
//   HOLD_CYCLES : post-point pause in clk cycles, >= 1
//   HOLD_W      : pause counter width, 2**HOLD_W > HOLD_CYCLES
// All outputs come straight from registers.
module pong_score
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_CYCLES = 50000000,
  parameter int HOLD_W      = 26
) (
  input  logic         clk,
  input  logic         reset,
  pong_score_if.slave  bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t             state;
  logic [SCORE_W-1:0] score_1_q;
  logic [SCORE_W-1:0] score_2_q;
  winner_t            winner_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               ball_hold_q;
  logic               playing_q;
  logic               game_over_q;

  logic               rise_1;
  logic               rise_2;
  logic [SCORE_W-1:0] score_1_inc;
  logic [SCORE_W-1:0] score_2_inc;

  rise_detect u_rise_1 (
    .clk   (clk),
    .reset (reset),
    .din   (bus.point_1),
    .rise  (rise_1)
  );

  rise_detect u_rise_2 (
    .clk   (clk),
    .reset (reset),
    .din   (bus.point_2),
    .rise  (rise_2)
  );

  assign score_1_inc = score_1_q + SCORE_W'(1);
  assign score_2_inc = score_2_q + SCORE_W'(1);

  // Match FSM with registered outputs. Every transition writes the outputs
  // for the state being entered, so the status lines change on the same edge
  // as the state. Player 1 has priority when both edges land together; the
  // player 2 edge is simply dropped. The pause counter is loaded with 0 on
  // entry to HOLD and leaves on HOLD_CYCLES-1, giving exactly HOLD_CYCLES
  // cycles of pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      score_1_q   <= '0;
      score_2_q   <= '0;
      winner_q    <= W_NONE;
      hold_cnt    <= '0;
      ball_hold_q <= 1'b1;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= PLAY;
            ball_hold_q <= 1'b0;
            playing_q   <= 1'b1;
          end
        end

        PLAY: begin
          if (rise_1) begin
            score_1_q   <= score_1_inc;
            ball_hold_q <= 1'b1;
            playing_q   <= 1'b0;
            if (score_1_inc == WIN_VAL) begin
              state       <= OVER;
              winner_q    <= W_P1;
              game_over_q <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end else if (rise_2) begin
            score_2_q   <= score_2_inc;
            ball_hold_q <= 1'b1;
            playing_q   <= 1'b0;
            if (score_2_inc == WIN_VAL) begin
              state       <= OVER;
              winner_q    <= W_P2;
              game_over_q <= 1'b1;
            end else begin
              state    <= HOLD;
              hold_cnt <= '0;
            end
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= PLAY;
            ball_hold_q <= 1'b0;
            playing_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        OVER: begin
          if (bus.start) begin
            state       <= PLAY;
            score_1_q   <= '0;
            score_2_q   <= '0;
            winner_q    <= W_NONE;
            ball_hold_q <= 1'b0;
            playing_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          ball_hold_q <= 1'b1;
          playing_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score_1   = score_1_q;
  assign bus.score_2   = score_2_q;
  assign bus.winner    = winner_q;
  assign bus.ball_hold = ball_hold_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_pong_score.sv
// tb_pong_score
// Scoreboard bench for pong_score (WIN_SCORE=3, HOLD_CYCLES=4). A reference
// model samples the inputs on each rising edge, computes the expected outputs
// after that edge from the match rules and pushes them into a queue; a
// separate monitor pops one entry on each falling edge and compares it with
// the DUT. Stimulus is a directed walk through the match followed by a
// randomised phase.
module tb_pong_score;

  localparam int WIN  = 3;
  localparam int HOLD = 4;

  typedef struct {
    int s1;
    int s2;
    bit hold;
    bit playing;
    bit over;
    int win;
  } exp_t;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  exp_t exp_q[$];

  pong_score_if bus ();

  pong_score #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLD),
    .HOLD_W      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: modes 0=waiting for start, 1=rally, 2=pause, 3=decided.
  // The pause is tracked as cycles remaining rather than a count-up.
  initial begin
    int   mode;
    int   s1;
    int   s2;
    int   win;
    int   pause_left;
    bit   last_1;
    bit   last_2;
    bit   e1;
    bit   e2;
    exp_t e;
    mode = 0; s1 = 0; s2 = 0; win = 0; pause_left = 0;
    last_1 = 0; last_2 = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mode = 0; s1 = 0; s2 = 0; win = 0; pause_left = 0;
        last_1 = 0; last_2 = 0;
      end else begin
        e1 = bus.point_1 && !last_1;
        e2 = bus.point_2 && !last_2;
        if (mode == 0) begin
          if (bus.start) mode = 1;
        end else if (mode == 1) begin
          if (e1) begin
            s1++;
            if (s1 == WIN) begin mode = 3; win = 1; end
            else begin mode = 2; pause_left = HOLD; end
          end else if (e2) begin
            s2++;
            if (s2 == WIN) begin mode = 3; win = 2; end
            else begin mode = 2; pause_left = HOLD; end
          end
        end else if (mode == 2) begin
          pause_left--;
          if (pause_left == 0) mode = 1;
        end else begin
          if (bus.start) begin
            s1 = 0; s2 = 0; win = 0; mode = 1;
          end
        end
        last_1 = bus.point_1;
        last_2 = bus.point_2;
      end
      e.s1      = s1;
      e.s2      = s2;
      e.hold    = (mode != 1);
      e.playing = (mode == 1);
      e.over    = (mode == 3);
      e.win     = win;
      exp_q.push_back(e);
    end
  end

  // Compare one expected entry against the DUT outputs.
  task automatic check_output(input exp_t e);
    bit bad;
    bad = 1'b0;
    if (bus.score_1   !== 4'(e.s1))    bad = 1'b1;
    if (bus.score_2   !== 4'(e.s2))    bad = 1'b1;
    if (bus.ball_hold !== e.hold)      bad = 1'b1;
    if (bus.playing   !== e.playing)   bad = 1'b1;
    if (bus.game_over !== e.over)      bad = 1'b1;
    if (bus.winner    !== 2'(e.win))   bad = 1'b1;
    n_compared++;
    if (bad) begin
      n_mismatched++;
      $display("[TB] FAIL outputs @%0t: got s1=%0d s2=%0d hold=%b play=%b over=%b win=%b, want s1=%0d s2=%0d hold=%b play=%b over=%b win=%b",
               $time, bus.score_1, bus.score_2, bus.ball_hold, bus.playing,
               bus.game_over, bus.winner, e.s1, e.s2, e.hold, e.playing,
               e.over, 2'(e.win));
    end
  endtask

  // Monitor: one popped expectation per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  // Hold the given input values for n cycles, changing just after the edge.
  task automatic apply_stimulus(input logic st, input logic p1, input logic p2,
                                input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      bus.start   = st;
      bus.point_1 = p1;
      bus.point_2 = p2;
      reset       = rst;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic lv1;
    logic lv2;
    n_compared   = 0;
    n_mismatched = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.point_1 = 1'b0;
    bus.point_2 = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] directed match walk");
    apply_stimulus(0, 0, 0, 1, 2);
    apply_stimulus(0, 0, 0, 0, 3);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);
    // Held point_1 counts once, then a 4-cycle pause.
    apply_stimulus(0, 1, 0, 0, 5);
    apply_stimulus(0, 0, 0, 0, 3);
    // Simultaneous edges, then a point_2 edge during the pause.
    apply_stimulus(0, 1, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 4);
    // Three point_2 edges finish the match for player 2.
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 0, 1, 0, 2);
      apply_stimulus(0, 0, 0, 0, 5);
    end
    apply_stimulus(0, 1, 0, 0, 2);
    apply_stimulus(0, 0, 0, 0, 2);
    // Restart from OVER, score once, reset mid-pause, edges in IDLE.
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1);
    apply_stimulus(0, 1, 1, 0, 2);
    apply_stimulus(0, 0, 0, 0, 2);
    apply_stimulus(1, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 2);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 2);

    $display("[TB] randomised phase");
    lv1 = 1'b0;
    lv2 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) lv1 = ~lv1;
      if ($urandom_range(0, 5) == 0) lv2 = ~lv2;
      apply_stimulus(logic'($urandom_range(0, 11) == 0), lv1, lv2,
                     logic'($urandom_range(0, 149) == 0), 1);
    end
    apply_stimulus(0, 0, 0, 0, 2);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
